// File: rtl/vga_pkg.sv
// Display timing constants and types shared by vga_ctrl and the line fetcher.
package vga_pkg;
  localparam logic [9:0] H_DISPLAY   = 10'd640;
  localparam logic [9:0] V_DISPLAY   = 10'd480;
  localparam logic [9:0] PIX_INVALID = 10'h3FF;

  typedef logic [15:0] rgb565_t;

  typedef enum logic {IDLE, FETCH} fetch_state_t;

  // Registered fetch trigger: which bank to fill and whether it is the frame's row 0.
  typedef struct packed {
    logic hit;
    logic first;
    logic bank;
  } fetch_trig_t;
endpackage

// File: rtl/vga_line_buf.sv
// Ping-pong line buffer: two banks of DEPTH RGB565 words, one sync write, one async read.
module vga_line_buf
  import vga_pkg::*;
#(
  parameter int DEPTH = 160,
  parameter int COL_W = 8
) (
  input  logic             vga_clk,
  input  logic             we,
  input  logic             wbank,
  input  logic [COL_W-1:0] wcol,
  input  rgb565_t          wdata,
  input  logic             rbank,
  input  logic [COL_W-1:0] rcol,
  output rgb565_t          rdata
);

  rgb565_t bank_rd [2];

  for (genvar b = 0; b < 2; b++) begin : g_bank
    rgb565_t mem [DEPTH];

    always_ff @(posedge vga_clk)
      if (we && wbank == 1'(b)) mem[wcol] <= wdata;

    assign bank_rd[b] = mem[rcol];
  end

  assign rdata = bank_rd[rbank];

endmodule

// File: rtl/vga_line_fetch.sv
// Fetches 160x120 source rows into a ping-pong line buffer and upscales x4 onto the
// 640x480 raster presented on pix_x/pix_y.
module vga_line_fetch
  import vga_pkg::*;
#(
  parameter int          SRC_W       = 160,
  parameter int          SRC_H       = 120,
  parameter int          SCALE_SHIFT = 2,
  parameter int          ADDR_W      = 15,
  parameter logic [15:0] BLACK       = 16'h0000
) (
  input  logic              vga_clk,
  input  logic              sys_rst,
  input  logic [9:0]        pix_x,
  input  logic [9:0]        pix_y,
  output logic [15:0]       pix_data,
  output logic              fb_rd_req,
  output logic [ADDR_W-1:0] fb_rd_addr,
  input  logic              fb_rd_ack,
  input  logic [15:0]       fb_rd_data,
  output logic              underrun
);

  localparam int COL_W = $clog2(SRC_W);

  logic             act;
  logic [9:0]       src_row;
  logic [COL_W-1:0] src_col;
  logic             rbank;
  rgb565_t          lb_rd;

  assign act     = pix_x != PIX_INVALID && pix_y != PIX_INVALID &&
                   pix_x < H_DISPLAY && pix_y < V_DISPLAY;
  assign src_row = pix_y >> SCALE_SHIFT;
  assign src_col = COL_W'(pix_x >> SCALE_SHIFT);
  assign rbank   = src_row[0];

  // Row r+1 is requested at the end of the first display line of row r.
  logic        eol, t0, tn;
  fetch_trig_t trig_d, trig_q;

  assign eol    = act && pix_x == H_DISPLAY - 10'd1;
  assign t0     = eol && pix_y == V_DISPLAY - 10'd1;
  assign tn     = eol && pix_y[SCALE_SHIFT-1:0] == '0 && src_row < 10'(SRC_H - 1);
  assign trig_d = '{hit: t0 || tn, first: t0, bank: t0 ? 1'b0 : ~src_row[0]};

  fetch_state_t      state, state_n;
  logic [COL_W-1:0]  col;
  logic [ADDR_W-1:0] row_base, base_n;
  logic              tbank;
  logic [1:0]        bank_valid;
  logic              accept, wr, last;

  // Running row base follows every trigger, accepted or not, so it stays aligned to the raster.
  assign base_n = trig_q.first ? '0 : row_base + ADDR_W'(SRC_W);
  assign last   = col == COL_W'(SRC_W - 1);

  always_comb begin
    state_n = state;
    accept  = 1'b0;
    wr      = 1'b0;
    case (state)
      IDLE:
        if (trig_q.hit) begin
          accept  = 1'b1;
          state_n = FETCH;
        end
      FETCH:
        if (fb_rd_ack) begin
          wr = 1'b1;
          if (last) state_n = IDLE;
        end
    endcase
  end

  assign fb_rd_req = state == FETCH;

  always_ff @(posedge vga_clk or posedge sys_rst)
    if (sys_rst) begin
      state      <= IDLE;
      trig_q     <= '0;
      row_base   <= '0;
      fb_rd_addr <= '0;
      col        <= '0;
      tbank      <= 1'b0;
      bank_valid <= '0;
      underrun   <= 1'b0;
    end else begin
      state    <= state_n;
      trig_q   <= trig_d;
      underrun <= act && pix_x == '0 && !bank_valid[rbank];
      if (trig_q.hit) row_base <= base_n;
      if (accept) begin
        tbank                    <= trig_q.bank;
        col                      <= '0;
        fb_rd_addr               <= base_n;
        bank_valid[trig_q.bank]  <= 1'b0;
      end else if (wr) begin
        if (last) bank_valid[tbank] <= 1'b1;
        else begin
          col        <= col + 1'b1;
          fb_rd_addr <= fb_rd_addr + 1'b1;
        end
      end
    end

  vga_line_buf #(.DEPTH(SRC_W), .COL_W(COL_W)) u_lb (
    .vga_clk (vga_clk),
    .we      (wr),
    .wbank   (tbank),
    .wcol    (col),
    .wdata   (fb_rd_data),
    .rbank   (rbank),
    .rcol    (src_col),
    .rdata   (lb_rd)
  );

  assign pix_data = (act && bank_valid[rbank]) ? lb_rd : BLACK;

endmodule
